// File: rtl/mem_pkg.sv
// Shared state encodings, transfer-size codes and the size-to-byte-mask helper
// for the data-memory bus adapter.
package mem_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    // A zero mask marks an unsupported transfer size.
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane shifter: byte enables and lane-aligned write data per beat, plus the
// right-justified read path. Beat-1 ports exist only with DMEM_MISALIGN_SPLIT_EN.
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [31:0] wr_data,
    input  logic [31:0] bus_rdata,
`ifdef DMEM_MISALIGN_SPLIT_EN
    input  logic [31:0] data_r,
    output logic [3:0]  be1,
    output logic [31:0] wdata1,
    output logic [31:0] rd_merge,
`endif
    output logic        crossing,
    output logic [3:0]  be0,
    output logic [31:0] wdata0,
    output logic [31:0] rd_single
);

    logic [3:0]  mask;
    logic [31:0] byte_mask;
    logic [5:0]  lo_sh;

    assign mask      = size_mask(size);
    assign byte_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    assign lo_sh     = {1'b0, off, 3'b000};
    assign crossing  = ({2'b00, off} + {1'b0, size}) > 4'd4;

    assign be0       = mask << off;
    assign wdata0    = wr_data << lo_sh;
    assign rd_single = (bus_rdata >> lo_sh) & byte_mask;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [5:0] hi_sh;

    // Beat 1 carries the bytes that spilled past the top lane of beat 0.
    assign hi_sh    = 6'd32 - lo_sh;
    assign be1      = mask >> (3'd4 - {1'b0, off});
    assign wdata1   = wr_data >> hi_sh;
    assign rd_merge = (data_r | (bus_rdata << hi_sh)) & byte_mask;
`endif

endmodule

// File: rtl/dmem_bus_adapter.sv
// MEM-stage adapter: runs load/store requests as word beats with byte enables and
// stalls the pipe until done. DMEM_MISALIGN_SPLIT_EN splits word-crossing accesses.
module dmem_bus_adapter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  xfer_size,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // state | meaning
    // IDLE  | waiting for a request; stall raised combinationally on a valid one
    // BEAT0 | first (or only) beat outstanding on the bus
    // BEAT1 | second beat of a word-crossing access (split build only)
    // DONE  | rd_data/err valid for this cycle, stall released

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [CW-1:0] tmo_cnt;
    logic          req_ok, in_beat, tmo_hit, start, beat_end, crossing;
    logic [3:0]    be0;
    logic [31:0]   wdata0, rd_single;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [3:0]  be1;
    logic [31:0] wdata1, rd_merge, data_r;
    logic        to_beat1;
`else
    logic        mis_err;
`endif

    dmem_lane_align u_align (
        .off       (addr[1:0]),
        .size      (xfer_size),
        .wr_data   (wr_data),
        .bus_rdata (bus_rdata),
`ifdef DMEM_MISALIGN_SPLIT_EN
        .data_r    (data_r),
        .be1       (be1),
        .wdata1    (wdata1),
        .rd_merge  (rd_merge),
`endif
        .crossing  (crossing),
        .be0       (be0),
        .wdata0    (wdata0),
        .rd_single (rd_single)
    );

    assign req_ok  = (load | store) && (size_mask(xfer_size) != 4'b0000);
    assign in_beat = (state == S_BEAT0) || (state == S_BEAT1);
    // Gated by rst_n so the pipe is released the instant reset hits.
    assign stall   = rst_n && (in_beat || ((state == S_IDLE) && req_ok));
    assign tmo_hit = (TIMEOUT != 0) && !bus_ack && (tmo_cnt == CW'(TIMEOUT - 1));

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign start    = (state == S_IDLE) && req_ok;
    assign to_beat1 = (state == S_BEAT0) && bus_ack && crossing;
    assign beat_end = in_beat && (bus_ack || tmo_hit) && !to_beat1;
`else
    assign start    = (state == S_IDLE) && req_ok && !crossing;
    assign mis_err  = (state == S_IDLE) && req_ok && crossing;
    assign beat_end = in_beat && (bus_ack || tmo_hit);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
            err     <= 1'b0;
            rd_data <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            data_r  <= '0;
`endif
        end else begin
            err     <= 1'b0;
            rd_data <= '0;
            if (in_beat && !bus_ack && !tmo_hit)
                tmo_cnt <= tmo_cnt + CW'(1);
            else
                tmo_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_BEAT0;
`ifndef DMEM_MISALIGN_SPLIT_EN
                    if (mis_err) begin
                        state <= S_DONE;
                        err   <= 1'b1;
                    end
`endif
                end
                S_BEAT0: begin
                    if (bus_ack) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                        if (crossing) begin
                            state  <= S_BEAT1;
                            data_r <= rd_single;
                        end else
`endif
                        begin
                            state   <= S_DONE;
                            rd_data <= rd_single;
                        end
                    end else if (tmo_hit) begin
                        state <= S_DONE;
                        err   <= 1'b1;
                    end
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                S_BEAT1: begin
                    if (bus_ack) begin
                        state   <= S_DONE;
                        rd_data <= rd_merge;
                    end else if (tmo_hit) begin
                        state <= S_DONE;
                        err   <= 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= store;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be0;
            bus_wdata <= wdata0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        end else if (to_beat1) begin
            bus_addr  <= bus_addr + 32'd4;
            bus_be    <= be1;
            bus_wdata <= wdata1;
`endif
        end else if (beat_end) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end
    end

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Scoreboard bench for dmem_bus_adapter: a byte-level memory model predicts bus beats
// and completions; a bus responder and a completion monitor check them independently.
module tb_dmem_bus_adapter;

    localparam int TMO = 4;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_cyc;
    } beat_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stall;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load, store;
    logic [2:0]  xfer_size;
    logic [31:0] addr, wr_data, rd_data;
    logic        stall, err;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    beat_t beat_q[$];
    resp_t resp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    dmem_bus_adapter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .store     (store),
        .xfer_size (xfer_size),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .stall     (stall),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-level model: byte s of wr_data lives at address addr+s; each word touched
    // by bytes 0..size-1 is one beat; read byte i comes from the word holding addr+i.
    task automatic run_xfer(input bit ld, input bit st, input logic [2:0] sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int w0, input int w1,
                            input logic [31:0] r0, input logic [31:0] r1);
        beat_t       b;
        resp_t       r;
        logic [31:0] w_first, w_last, word, ba;
        logic [31:0] rds[2];
        int          waits[2];
        int          nb, cyc;
        waits[0] = w0;  waits[1] = w1;
        rds[0]   = r0;  rds[1]   = r1;
        w_first  = a >> 2;
        w_last   = (a + 32'(sz) - 32'd1) >> 2;
        nb       = (w_first == w_last) ? 1 : 2;
        r.rd = '0;  r.err = 1'b0;  r.stall = 1;
        if (nb == 2 && !SPLIT) begin
            r.err = 1'b1;
        end else begin
            for (int k = 0; k < nb; k++) begin
                word       = w_first + 32'(k);
                b.addr     = word << 2;
                b.be       = '0;
                b.we       = st;
                b.wdata    = '0;
                b.rdata    = rds[k];
                b.wait_cyc = waits[k];
                for (int s = 0; s < 4; s++) begin
                    ba = a + 32'(s);
                    if ((ba >> 2) == word) begin
                        b.wdata[8*ba[1:0] +: 8] = wd[8*s +: 8];
                        if (s < int'(sz)) b.be[ba[1:0]] = 1'b1;
                    end
                end
                beat_q.push_back(b);
                if (waits[k] >= TMO) begin
                    r.stall += TMO;
                    r.err    = 1'b1;
                    r.rd     = '0;
                    break;
                end
                r.stall += waits[k] + 1;
                for (int i = 0; i < int'(sz); i++) begin
                    ba = a + 32'(i);
                    if ((ba >> 2) == word) r.rd[8*i +: 8] = rds[k][8*ba[1:0] +: 8];
                end
            end
        end
        resp_q.push_back(r);
        load = ld;  store = st;  xfer_size = sz;  addr = a;  wr_data = wd;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (stall && cyc < 64);
        check("xfer_complete", 32'(stall), 32'd0);
        load = 1'b0;  store = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_invalid(input logic [2:0] sz);
        load = 1'b1;  store = 1'($urandom_range(0, 1));  xfer_size = sz;  addr = $urandom;
        #1 check("invalid_size_stall", 32'(stall), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("invalid_size_stall", 32'(stall), 32'd0);
        end
        load = 1'b0;  store = 1'b0;
    endtask

    task automatic run_reset_mid_beat();
        beat_t b;
        b.addr = 32'h400;  b.be = 4'hF;  b.we = 1'b0;  b.wdata = 32'h0;
        b.rdata = 32'h0;   b.wait_cyc = 1000;
        beat_q.push_back(b);
        load = 1'b1;  store = 1'b0;  xfer_size = 3'd4;  addr = 32'h400;  wr_data = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_bus_req", 32'(bus_req), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_bus_be", 32'(bus_be), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        load = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin : responder
        beat_t b;
        int    left;
        bit    active;
        bus_ack = 1'b0;  bus_rdata = '0;  active = 1'b0;  left = 0;
        forever begin
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (!rst_n || !bus_req) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", 32'(bus_req), 32'd0);
                    end else begin
                        b      = beat_q.pop_front();
                        active = 1'b1;
                        left   = b.wait_cyc;
                    end
                end
                if (active) begin
                    check("bus_addr", bus_addr, b.addr);
                    check("bus_be", 32'(bus_be), 32'(b.be));
                    check("bus_we", 32'(bus_we), 32'(b.we));
                    check("bus_wdata", bus_wdata, b.wdata);
                    if (left == 0) begin
                        bus_ack   = 1'b1;
                        bus_rdata = b.rdata;
                        active    = 1'b0;
                    end else begin
                        left--;
                    end
                end
            end
        end
    end

    initial begin : monitor
        resp_t r;
        int    scnt;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                scnt = 0;
            end else if (stall) begin
                scnt++;
            end else begin
                if (scnt > 0) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_done", 32'(scnt), 32'd0);
                    end else begin
                        r = resp_q.pop_front();
                        check("rd_data", rd_data, r.rd);
                        check("err_done", 32'(err), 32'(r.err));
                        check("stall_cycles", 32'(scnt), 32'(r.stall));
                        check("bus_req_done", 32'(bus_req), 32'd0);
                    end
                end else begin
                    check("err_idle", 32'(err), 32'd0);
                end
                scnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int sel, wsel, w0, w1;
        logic [2:0] sz;
        rst_n = 1'b0;  load = 1'b0;  store = 1'b0;  xfer_size = '0;  addr = '0;  wr_data = '0;
        @(posedge clk); #1;
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_xfer(1'b1, 1'b0, 3'd4, 32'h100, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF, 32'h0);
        run_xfer(1'b0, 1'b1, 3'd1, 32'h203, 32'h0000_00A5, 0, 0, 32'h1111_2222, 32'h0);
        run_xfer(1'b1, 1'b0, 3'd2, 32'h307, 32'h0, 0, 0, 32'hAB00_0000, 32'h0000_00CD);
        run_xfer(1'b1, 1'b0, 3'd4, 32'h500, 32'h0, TMO, 0, 32'h5555_AAAA, 32'h0);
        run_xfer(1'b1, 1'b0, 3'd4, 32'h504, 32'h0, TMO - 1, 0, 32'h0BAD_F00D, 32'h0);
        run_xfer(1'b1, 1'b1, 3'd2, 32'h602, 32'hCAFE_BABE, 1, 0, 32'h7777_8888, 32'h0);
        run_xfer(1'b0, 1'b1, 3'd4, 32'h701, 32'h8765_4321, 0, TMO, 32'h9999_0000, 32'h1234_4321);
        run_xfer(1'b1, 1'b0, 3'd4, 32'h803, 32'h0, 2, 1, 32'hA1B2_C3D4, 32'hE5F6_0718);
        run_invalid(3'd0);
        run_invalid(3'd3);
        run_invalid(3'd5);
        run_invalid(3'd7);
        run_reset_mid_beat();
        run_xfer(1'b1, 1'b0, 3'd4, 32'h400, 32'h0, 0, 0, 32'h600D_600D, 32'h0);

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0:       sz = 3'd1;
                1:       sz = 3'd2;
                default: sz = 3'd4;
            endcase
            wsel = $urandom_range(0, 9);
            w0   = (wsel < 7) ? $urandom_range(0, 2) : (wsel == 7) ? TMO - 1 : (wsel == 8) ? TMO : 0;
            w1   = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 2);
            run_xfer(sel != 1, sel != 0, sz, $urandom & 32'h0FFF_FFFF, $urandom,
                     w0, w1, $urandom, $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        check("beat_q_drained", 32'(beat_q.size()), 32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_adapter.md
Name: dmem_bus_adapter

Overview:
- Sits directly downstream of the memory controller in the MEM stage.
- Takes the load/store strobe, transfer size, byte address and right-justified store data, and runs a multi-cycle handshake on a 32-bit word-addressed data bus with byte enables.
- Returns right-justified read data as the controller's MEM_rd_data and stalls the pipeline until the access completes.
- Accesses that cross a word boundary are split into two bus beats, or reported as an error (see Optional Feature).

Parameters:
- TIMEOUT, 255, cycles a beat may wait for bus_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  load request, held stable while stall=1
- store  in  1  store request, held stable while stall=1
- xfer_size  in  3  bytes to transfer: 1, 2 or 4
- addr  in  32  byte address
- wr_data  in  32  right-justified store data
- rd_data  out  32  right-justified raw read data, zero-filled above the access size
- stall  out  1  pipeline hold
- err  out  1  one-cycle pulse: timeout or misalign
- bus_req  out  1  beat request
- bus_we  out  1  write beat
- bus_addr  out  32  word-aligned address, bits [1:0]=0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned write data
- bus_ack  in  1  beat complete; bus_rdata valid in the same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset (asynchronous, any state): state=IDLE; rd_data=0; err=0; bus_req=0; bus_we=0; bus_addr=0; bus_be=0; bus_wdata=0; timeout counter=0. A reset during an active beat drops bus_req immediately.
- Valid request: (load|store) and xfer_size in {1,2,4}.
  - Any other xfer_size is ignored: no beat, stall=0.
  - load and store both high: the access runs as a store.
- Byte lanes:
  - off = addr[1:0]; mask = 1, 3 or 15 for size 1, 2 or 4.
  - Beat 0: bus_be = (mask<<off)[3:0]; bus_wdata = wr_data<<(8*off); bus_addr = {addr[31:2],2'b00}.
  - A crossing access (off+size>4) also needs beat 1: bus_addr + 4; bus_be = mask>>(4-off); bus_wdata = wr_data>>(8*(4-off)).
- FSM states:
  - IDLE: on a valid request go to BEAT0. stall=1 combinationally in this cycle.
  - BEAT0: bus_req=1, stall=1. On bus_ack, latch bus_rdata>>(8*off) into the low bytes of a data register. Next state is BEAT1 if crossing, else DONE.
  - BEAT1: bus_req=1, stall=1. On bus_ack, merge bus_rdata into byte positions [4-off .. size-1]. Next state is DONE.
  - DONE: stall=0 and rd_data is valid for exactly this cycle; the pipeline advances. Next state is IDLE; no new request is accepted in DONE.
  - Bytes above xfer_size in rd_data are 0.
- Latency: aligned access with ack on the first cycle = 3 cycles (IDLE, BEAT0, DONE); a split access adds 1 cycle plus any ack wait.
- Bus outputs are registered and stable for the whole beat; bus_req falls in the cycle after ack.
- Timeout: the counter increments each beat cycle without ack and clears on ack.
  - When the counter reaches TIMEOUT: pulse err, rd_data=0, go to DONE, and issue no further beats.
  - Stores already acked on beat 0 are not rolled back.
- bus_ack outside BEAT0/BEAT1 is ignored.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- Defined: crossing accesses split into two beats as described above.
- Undefined: a crossing request goes IDLE→DONE without bus activity; err pulses in DONE, rd_data=0, stall is high for one cycle only. BEAT1 logic is not compiled.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE, BEAT0, BEAT1, DONE)
  - size constants SZ_B=1, SZ_H=2, SZ_W=4
  - function size_mask(size)→4-bit
- One natural sub-module, dmem_lane_align: combinational shifter producing be/wdata for each beat and the read merge. The FSM and timeout counter stay in the top.

Test Plan:
- Aligned LW addr=0x100, bus_rdata=0xDEADBEEF, ack on the first request cycle → bus_be=4'hF, bus_addr=0x100, rd_data=0xDEADBEEF in DONE, stall high for 2 cycles.
- SB addr=0x203, wr_data=0x000000A5 → bus_be=4'b1000, bus_wdata=0xA5000000, bus_we=1, a single beat.
- LH addr=0x307 with the split macro defined, beat 0 rdata=0xAB000000, beat 1 rdata=0x000000CD → bus_addr 0x304 then 0x308, be 4'b1000 then 4'b0001, rd_data=0x0000CDAB.
- Same LH with the macro undefined → no bus_req, err pulse, rd_data=0, stall high for 1 cycle.
- LW with bus_ack withheld, TIMEOUT=4 → err pulses after 4 waiting cycles, stall releases, bus_req drops.
- rst_n asserted mid-BEAT0 → bus_req=0 and stall=0 immediately; after release a new LW completes normally.
